// File: rtl/if_stage_ctrl_pkg.sv
// rtl/if_stage_ctrl_pkg.sv - shared fetch-stage constants, state encoding and helpers
package if_stage_ctrl_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_ctrl_if.sv
// rtl/if_stage_ctrl_if.sv - hazard/branch requests, imem and IF/ID signals around the fetch controller
interface if_stage_ctrl_if;

  logic        pc_stall;
  logic        IF_ID_stall;
  logic        ID_EX_flush_lw;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] inst_in;
  logic [31:0] pc;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;
  logic        ID_EX_clear;

  // master is the fetch controller; slave is the surrounding pipeline
  modport master (
    input  pc_stall, IF_ID_stall, ID_EX_flush_lw, branch_taken, branch_target, inst_in,
    output pc, IF_ID_pc, IF_ID_inst, IF_ID_valid, ID_EX_clear
  );

  modport slave (
    output pc_stall, IF_ID_stall, ID_EX_flush_lw, branch_taken, branch_target, inst_in,
    input  pc, IF_ID_pc, IF_ID_inst, IF_ID_valid, ID_EX_clear
  );

endinterface

// File: rtl/if_stage_ctrl_sat_counter.sv
// rtl/if_stage_ctrl_sat_counter.sv - event counter that sticks at all-ones, cleared only by reset
module if_stage_ctrl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_stage_ctrl.sv
// rtl/if_stage_ctrl.sv - fetch-stage controller: PC, IF/ID register, stall/redirect handling
module if_stage_ctrl
  import if_stage_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_stage_ctrl_if.master      bus,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic                 stall_err,
  output logic                 align_err
);

  fetch_state_e state;
  logic         stall_eff;
  logic         stall_inc;

  assign stall_eff       = bus.pc_stall | bus.IF_ID_stall;
  assign stall_inc       = stall_eff & ~bus.branch_taken;
  assign bus.ID_EX_clear = bus.ID_EX_flush_lw | bus.branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      bus.pc          <= RESET_PC;
      bus.IF_ID_pc    <= 32'h0;
      bus.IF_ID_inst  <= NOP_INST;
      bus.IF_ID_valid <= 1'b0;
      stall_err       <= 1'b0;
      align_err       <= 1'b0;
    end else begin
      // The load-use detector drives both stall lines together for exactly one cycle
      if ((bus.pc_stall != bus.IF_ID_stall) || (stall_eff && (state == HOLD))) begin
        stall_err <= 1'b1;
      end

      if (bus.branch_taken) begin
        bus.pc          <= align_word(bus.branch_target);
        bus.IF_ID_pc    <= 32'h0;
        bus.IF_ID_inst  <= NOP_INST;
        bus.IF_ID_valid <= 1'b0;
        state           <= RUN;
        if (bus.branch_target[1:0] != 2'b00) begin
          align_err <= 1'b1;
        end
      end else if (stall_eff) begin
        state <= HOLD;
      end else begin
        bus.pc          <= bus.pc + 32'd4;
        bus.IF_ID_pc    <= bus.pc;
        bus.IF_ID_inst  <= bus.inst_in;
        bus.IF_ID_valid <= 1'b1;
        state           <= RUN;
      end
    end
  end

  if_stage_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  if_stage_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.branch_taken),
    .cnt   (flush_cnt)
  );

endmodule
